// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss/fill controller.
package cache_pkg;

  // Byte offset inside a 16-byte block and word index inside a block.
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_IDX_BITS     = 3;

  // Low bits cleared by this mask give the block base address.
  localparam int BLOCK_OFFSET_MASK = (1 << BLOCK_OFFSET_BITS) - 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Word slot inside the block: start offset plus counter, wrapping mod 8.
  function automatic logic [WORD_IDX_BITS-1:0] word_slot(
    input logic [WORD_IDX_BITS-1:0] start,
    input logic [WORD_IDX_BITS:0]   cnt
  );
    return start + cnt[WORD_IDX_BITS-1:0];
  endfunction

endpackage

// File: rtl/fill_word_ctr.sv
// Saturating word counter (3 index bits + 1 done bit) with enable and clear.
module fill_word_ctr
  import cache_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   en,
  output logic [WORD_IDX_BITS:0] count
);

  localparam logic [WORD_IDX_BITS:0] LIMIT_VAL = (WORD_IDX_BITS+1)'(LIMIT);

  logic [WORD_IDX_BITS:0] count_reg;

  // Count up while enabled, hold at LIMIT; clear wins over enable.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count_reg <= '0;
    end else if (en && (count_reg < LIMIT_VAL)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches a whole 8-word block from a pipelined
// read memory, writes each returning word into the data array and the tag
// on the last word. Optional macro CRITICAL_WORD_FIRST_EN starts the fill at
// the missed word instead of word 0.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  output logic                  fsm_busy,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  write_data_array,
  output logic                  write_tag_array,
  output logic [ADDR_WIDTH-1:0] fill_address,
  output logic [15:0]           fill_data
);

  localparam logic [WORD_IDX_BITS:0] WPB_VAL  = (WORD_IDX_BITS+1)'(WORDS_PER_BLOCK);
  localparam logic [WORD_IDX_BITS:0] LAST_VAL = (WORD_IDX_BITS+1)'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_WIDTH-1:0]  BASE_MASK = ~ADDR_WIDTH'(BLOCK_OFFSET_MASK);

  fill_state_t              state_reg;
  logic [ADDR_WIDTH-1:0]    base_reg;
  logic [WORD_IDX_BITS-1:0] start_reg;
  logic [WORD_IDX_BITS-1:0] start_next;
  logic [WORD_IDX_BITS:0]   issue_cnt;
  logic [WORD_IDX_BITS:0]   rcv_cnt;
  logic                     in_fill;
  logic                     issue_en;
  logic                     rcv_fire;
  logic                     last_rcv;

  assign in_fill  = (state_reg == FILL);
  assign issue_en = in_fill && (issue_cnt < WPB_VAL);
  assign rcv_fire = in_fill && memory_data_valid;
  assign last_rcv = rcv_fire && (rcv_cnt == LAST_VAL);

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_next = miss_address[BLOCK_OFFSET_BITS-1:1];
`else
  assign start_next = '0;
`endif

  fill_word_ctr #(.LIMIT(WORDS_PER_BLOCK)) u_issue_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (last_rcv),
    .en    (issue_en),
    .count (issue_cnt)
  );

  fill_word_ctr #(.LIMIT(WORDS_PER_BLOCK)) u_rcv_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (last_rcv),
    .en    (rcv_fire),
    .count (rcv_cnt)
  );

  // IDLE/FILL sequencing; block base and start word are latched on the miss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      base_reg  <= '0;
      start_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (miss_detected) begin
            base_reg  <= miss_address & BASE_MASK;
            start_reg <= start_next;
            state_reg <= FILL;
          end
        end
        FILL: begin
          if (last_rcv) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The first word cannot come back before the memory latency has elapsed.
  always_ff @(posedge clk) begin
    if (rst_n && rcv_fire && (rcv_cnt == '0)) begin
      assert (int'(issue_cnt) >= MEM_LATENCY);
    end
  end

  assign fsm_busy         = in_fill;
  assign mem_enable       = issue_en;
  assign memory_address   = in_fill ? (base_reg | ADDR_WIDTH'({word_slot(start_reg, issue_cnt), 1'b0}))
                                    : '0;
  assign write_data_array = rcv_fire;
  assign write_tag_array  = last_rcv;
  assign fill_address     = in_fill ? (base_reg | ADDR_WIDTH'({word_slot(start_reg, rcv_cnt), 1'b0}))
                                    : '0;
  assign fill_data        = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a 4-stage pipelined memory model.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_enable;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] fill_address;
  logic [15:0] fill_data;

  logic        spur_valid;
  logic [15:0] spur_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] addr;
    int          cyc;
  } iss_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        tag;
    int          cyc;
  } wr_t;

  iss_t iss_q[$];
  wr_t  wr_q[$];
  int   busy_q[$];

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_enable        (mem_enable),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .fill_address      (fill_address),
    .fill_data         (fill_data)
  );

  // Memory contents: block 0x1230 holds 0xA000..0xA007, elsewhere a hash.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a[15:4] == 12'h123) return 16'hA000 | {13'd0, a[3:1]};
    else                    return a ^ 16'h5A5A;
  endfunction

  // 4-cycle pipelined read memory, reset together with the controller.
  logic [3:0]  pv;
  logic [15:0] pa [0:3];
  always @(posedge clk) begin
    if (!rst_n) begin
      pv <= 4'd0;
    end else begin
      pv    <= {pv[2:0], mem_enable};
      pa[0] <= memory_address;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
  end
  assign memory_data_valid = pv[3] | spur_valid;
  assign memory_data       = pv[3] ? mem_word(pa[3]) : spur_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: counts fill cycles and pops the scoreboard on every strobe.
  int   fcyc = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin : monitor
    iss_t ie;
    wr_t  we;
    int   bl;
    if (fsm_busy) fcyc++;
    if (mem_enable) begin
      if (iss_q.size() == 0) fail_now("unexpected_issue");
      else begin
        ie = iss_q.pop_front();
        check("issue_addr", 32'(memory_address), 32'(ie.addr));
        check("issue_cycle", 32'(fcyc), 32'(ie.cyc));
        $display("ISSUE f%0d addr=0x%04h", fcyc, memory_address);
      end
    end
    if (write_data_array) begin
      if (wr_q.size() == 0) fail_now("unexpected_write");
      else begin
        we = wr_q.pop_front();
        check("fill_addr", 32'(fill_address), 32'(we.addr));
        check("fill_data", 32'(fill_data), 32'(we.data));
        check("tag_strobe", 32'(write_tag_array), 32'(we.tag));
        check("write_cycle", 32'(fcyc), 32'(we.cyc));
        $display("WRITE f%0d addr=0x%04h data=0x%04h tag=%0b", fcyc, fill_address, fill_data, write_tag_array);
      end
    end else if (write_tag_array) begin
      fail_now("tag_without_data");
    end
    if (!fsm_busy && prev_busy) begin
      if (busy_q.size() == 0) fail_now("unexpected_busy_fall");
      else begin
        bl = busy_q.pop_front();
        check("busy_len", 32'(fcyc), 32'(bl));
        $display("BUSY length=%0d", fcyc);
      end
    end
    if (!fsm_busy) fcyc = 0;
    prev_busy = fsm_busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] start_of(input logic [15:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
    return a[3:1];
`else
    return (a[3:1] & 3'd0);
`endif
  endfunction

  // Push the expected issues, writes and busy length for one fill.
  task automatic expect_fill(input logic [15:0] a, input int n_issue, input int n_wr, input int busy_len);
    logic [15:0] base;
    logic [2:0]  s;
    logic [2:0]  w;
    iss_t        ie;
    wr_t         we;
    base = a & 16'hFFF0;
    s    = start_of(a);
    for (int i = 0; i < n_issue; i++) begin
      w       = s + 3'(i);
      ie.addr = base | {12'd0, w, 1'b0};
      ie.cyc  = i + 1;
      iss_q.push_back(ie);
    end
    for (int i = 0; i < n_wr; i++) begin
      w       = s + 3'(i);
      we.addr = base | {12'd0, w, 1'b0};
      we.data = mem_word(we.addr);
      we.tag  = (i == 7);
      we.cyc  = i + 5;
      wr_q.push_back(we);
    end
    busy_q.push_back(busy_len);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (fsm_busy && n < budget) begin
      tick();
      n++;
    end
    if (fsm_busy) fail_now("busy_timeout");
  endtask

  task automatic run_fill(input logic [15:0] a);
    expect_fill(a, 8, 8, 12);
    miss_detected = 1'b1;
    miss_address  = a;
    tick();
    miss_detected = 1'b0;
    wait_idle(40);
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(fsm_busy), 32'd0);
    check({tag, "_mem_enable"}, 32'(mem_enable), 32'd0);
    check({tag, "_memory_address"}, 32'(memory_address), 32'd0);
    check({tag, "_write_data"}, 32'(write_data_array), 32'd0);
    check({tag, "_write_tag"}, 32'(write_tag_array), 32'd0);
    check({tag, "_fill_address"}, 32'(fill_address), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    miss_detected = 1'b0;
    miss_address  = 16'h0000;
    spur_valid    = 1'b0;
    spur_data     = 16'h0000;
    tick(); tick(); tick();
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Basic fill, critical-word address, top-of-memory block.
    run_fill(16'h1234);
    run_fill(16'h123A);
    run_fill(16'hFFF6);

    // Miss during busy: pulse ignored, held miss accepted after f12.
    expect_fill(16'h4000, 8, 8, 12);
    expect_fill(16'h3000, 8, 8, 12);
    miss_detected = 1'b1;
    miss_address  = 16'h4000;
    tick();                          // f1
    miss_detected = 1'b0;
    tick(); tick();                  // f3
    miss_detected = 1'b1;
    miss_address  = 16'h2000;
    tick();                          // f4
    miss_address  = 16'h3000;
    for (int i = 0; i < 8; i++) tick();  // f12
    tick();                          // cycle after f12
    check("gap_idle", 32'(fsm_busy), 32'd0);
    tick();
    check("second_fill_start", 32'(fsm_busy), 32'd1);
    miss_detected = 1'b0;
    miss_address  = 16'h7777;
    wait_idle(40);
    tick();

    // Reset at f6: partial block, no tag write, nothing afterwards.
    expect_fill(16'h5000, 6, 2, 6);
    miss_detected = 1'b1;
    miss_address  = 16'h5008;
    tick();                          // f1
    miss_detected = 1'b0;
    for (int i = 0; i < 5; i++) tick();  // f6
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_outputs_zero("midreset");

    // Spurious valid pulses in IDLE produce no strobes.
    spur_valid = 1'b1;
    spur_data  = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spur_write_data", 32'(write_data_array), 32'd0);
      check("spur_write_tag", 32'(write_tag_array), 32'd0);
      @(posedge clk); #1;
    end
    spur_valid = 1'b0;
    spur_data  = 16'h0000;
    tick();

    // Recovery after reset.
    run_fill(16'hABCE);
    tick(); tick();

    check("iss_q_empty", 32'(iss_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("busy_q_empty", 32'(busy_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
